singcyc_irq_ctrl: RTL and testbench

Interrupt controller and system timer that sequences the single-cycle core's `iInterrupt` input. It does four jobs:
- Collects one internal timer source and four external edge-triggered sources.
- Applies a per-source enable mask.
- Raises the interrupt request only while the core runs in user mode (PC[31]=0).
- Latches the cause at the moment the core enters its handler.

It sits on the core's data-memory bus as a memory-mapped peripheral. Its read path is combinational, so a `lw` completes in the core's single cycle.

---
 rtl/singcyc_irq_ctrl.sv | 172 +++++++++++++++++
 tb/tb_singcyc_irq_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/singcyc_irq_ctrl.sv
// Memory-mapped interrupt controller and system timer for the single-cycle core.
// Collects a timer source and four synchronised edge-triggered lines and drives the core's iInterrupt.
module singcyc_irq_ctrl #(
  parameter logic [31:0] BASE = 32'h40000000
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic [31:0] iAddr,
  input  logic [31:0] iWrData,
  input  logic        iMemWrite,
  input  logic        iMemRead,
  output logic [31:0] oRdData,
  output logic        oHit,
  input  logic [3:0]  iIrq,
  input  logic        iKernel,
  output logic        oInterrupt
);

  localparam logic [0:0] ARMED      = 1'b0;
  localparam logic [0:0] IN_SERVICE = 1'b1;

  localparam logic [2:0] IDX_TH    = 3'd0;
  localparam logic [2:0] IDX_TL    = 3'd1;
  localparam logic [2:0] IDX_TCON  = 3'd2;
  localparam logic [2:0] IDX_EN    = 3'd3;
  localparam logic [2:0] IDX_PEND  = 3'd4;
  localparam logic [2:0] IDX_CAUSE = 3'd5;

  logic [31:0] th;
  logic [31:0] tl;
  logic        run;
  logic [4:0]  en;
  logic [4:0]  pend;
  logic [2:0]  cause;
  logic [0:0]  state;
  logic        kernelQ;
  logic [3:0]  irqSync1;
  logic [3:0]  irqSync2;
  logic [3:0]  irqSync3;

  logic [2:0]  regIdx;
  logic        wrEn;
  logic        wrTh;
  logic        wrTl;
  logic        wrTcon;
  logic        wrEnMask;
  logic        wrPend;
  logic        overflow;
  logic [31:0] tlNext;
  logic [3:0]  irqRise;
  logic [4:0]  hwSet;
  logic [4:0]  w1cMask;
  logic [4:0]  pendNext;
  logic [4:0]  active;
  logic [2:0]  winner;

  assign regIdx = iAddr[4:2];
  assign oHit   = (iAddr[31:5] == BASE[31:5]) && (regIdx <= IDX_CAUSE) && (iAddr[1:0] == 2'b00);

  assign wrEn     = iMemWrite & oHit;
  assign wrTh     = wrEn && (regIdx == IDX_TH);
  assign wrTl     = wrEn && (regIdx == IDX_TL);
  assign wrTcon   = wrEn && (regIdx == IDX_TCON);
  assign wrEnMask = wrEn && (regIdx == IDX_EN);
  assign wrPend   = wrEn && (regIdx == IDX_PEND);

  // A software store to TL beats both the increment and the overflow event.
  assign overflow = run && (tl == 32'hFFFFFFFF) && !wrTl;

  always_comb begin
    tlNext = tl;
    if (wrTl) begin
      tlNext = iWrData;
    end else if (run) begin
      tlNext = (tl == 32'hFFFFFFFF) ? th : tl + 32'd1;
    end
  end

  assign irqRise  = irqSync2 & ~irqSync3;
  assign hwSet    = {irqRise, overflow};
  assign w1cMask  = wrPend ? iWrData[4:0] : 5'b00000;
  assign pendNext = (pend & ~w1cMask) | hwSet;

  assign active = pend & en;

  always_comb begin
    winner = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (active[i]) begin
        winner = 3'(i);
      end
    end
  end

  assign oInterrupt = (state == ARMED) && (|active) && !iKernel;

  always_comb begin
    oRdData = 32'h0;
    if (oHit && iMemRead) begin
      case (regIdx)
        IDX_TH:    oRdData = th;
        IDX_TL:    oRdData = tl;
        IDX_TCON:  oRdData = {31'h0, run};
        IDX_EN:    oRdData = {27'h0, en};
        IDX_PEND:  oRdData = {27'h0, pend};
        IDX_CAUSE: oRdData = {29'h0, cause};
        default:   oRdData = 32'h0;
      endcase
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      irqSync1 <= 4'h0;
      irqSync2 <= 4'h0;
      irqSync3 <= 4'h0;
    end else begin
      irqSync1 <= iIrq;
      irqSync2 <= irqSync1;
      irqSync3 <= irqSync2;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      th   <= 32'h0;
      tl   <= 32'h0;
      run  <= 1'b0;
      en   <= 5'h0;
      pend <= 5'h0;
    end else begin
      if (wrTh) begin
        th <= iWrData;
      end
      if (wrTcon) begin
        run <= iWrData[0];
      end
      if (wrEnMask) begin
        en <= iWrData[4:0];
      end
      tl   <= tlNext;
      pend <= pendNext;
    end
  end

  // kernelQ is cleared on entry so the take cycle (iKernel still 0) cannot re-arm at once.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state   <= ARMED;
      cause   <= 3'd0;
      kernelQ <= 1'b0;
    end else begin
      case (state)
        ARMED: begin
          kernelQ <= 1'b0;
          if (oInterrupt) begin
            cause <= winner;
            state <= IN_SERVICE;
          end
        end
        IN_SERVICE: begin
          kernelQ <= iKernel;
          if (kernelQ && !iKernel) begin
            state <= ARMED;
          end
        end
        default: state <= ARMED;
      endcase
    end
  end

endmodule

// File: tb/tb_singcyc_irq_ctrl.sv
// Self-checking bench for singcyc_irq_ctrl: register table, timer, take/return, priority,
// collisions and reset during service.
module tb_singcyc_irq_ctrl;

  localparam logic [31:0] BASE   = 32'h40000000;
  localparam logic [31:0] A_TH   = BASE + 32'h00;
  localparam logic [31:0] A_TL   = BASE + 32'h04;
  localparam logic [31:0] A_TCON = BASE + 32'h08;
  localparam logic [31:0] A_EN   = BASE + 32'h0C;
  localparam logic [31:0] A_PEND = BASE + 32'h10;
  localparam logic [31:0] A_CAUS = BASE + 32'h14;

  logic        iClk = 1'b0;
  logic        iRst_n;
  logic [31:0] iAddr;
  logic [31:0] iWrData;
  logic        iMemWrite;
  logic        iMemRead;
  logic [31:0] oRdData;
  logic        oHit;
  logic [3:0]  iIrq;
  logic        iKernel;
  logic        oInterrupt;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    string       name;
    logic        doWr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRd;
    logic        expHit;
  } vec_t;
  vec_t tbl[11];

  singcyc_irq_ctrl #(.BASE(BASE)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iAddr(iAddr), .iWrData(iWrData),
    .iMemWrite(iMemWrite), .iMemRead(iMemRead), .oRdData(oRdData), .oHit(oHit),
    .iIrq(iIrq), .iKernel(iKernel), .oInterrupt(oInterrupt)
  );

  always #10 iClk = ~iClk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %h", name, act);
    end
  endtask

  task automatic idle();
    @(posedge iClk);
    @(negedge iClk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    iAddr = a;
    iWrData = d;
    iMemWrite = 1'b1;
    @(posedge iClk);
    @(negedge iClk);
    iMemWrite = 1'b0;
  endtask

  // Expected value is queued when the load is issued and popped when the bus answers.
  task automatic rdExp(input string name, input logic [31:0] a, input logic [31:0] exp);
    sb_t e;
    sb_t got;
    e.name = name;
    e.exp = exp;
    sbq.push_back(e);
    iAddr = a;
    iMemRead = 1'b1;
    #1;
    if (sbq.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard: empty queue for %s", name);
    end else begin
      got = sbq.pop_front();
      check(got.name, oRdData, got.exp);
    end
    iMemRead = 1'b0;
  endtask

  task automatic waitInt(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (oInterrupt) begin
        seen = 1'b1;
        break;
      end
      idle();
    end
    check(name, {31'h0, seen}, 32'h1);
  endtask

  initial begin
    tbl[0]  = '{"tbl_th",        1'b1, A_TH,          32'h12345678, 32'h12345678, 1'b1};
    tbl[1]  = '{"tbl_tl",        1'b1, A_TL,          32'h00000055, 32'h00000055, 1'b1};
    tbl[2]  = '{"tbl_tcon_mask", 1'b1, A_TCON,        32'hFFFFFFFE, 32'h00000000, 1'b1};
    tbl[3]  = '{"tbl_en_mask",   1'b1, A_EN,          32'hFFFFFFFF, 32'h0000001F, 1'b1};
    tbl[4]  = '{"tbl_pend_w1c",  1'b1, A_PEND,        32'h0000001F, 32'h00000000, 1'b1};
    tbl[5]  = '{"tbl_cause_ro",  1'b1, A_CAUS,        32'h00000007, 32'h00000000, 1'b1};
    tbl[6]  = '{"tbl_range",     1'b1, BASE + 32'h18, 32'h0000DEAD, 32'h00000000, 1'b0};
    tbl[7]  = '{"tbl_misalign",  1'b1, BASE + 32'h02, 32'h0000AAAA, 32'h00000000, 1'b0};
    tbl[8]  = '{"tbl_window",    1'b1, BASE + 32'h20, 32'h0000BBBB, 32'h00000000, 1'b0};
    tbl[9]  = '{"tbl_th_kept",   1'b0, A_TH,          32'h00000000, 32'h12345678, 1'b1};
    tbl[10] = '{"tbl_en_clear",  1'b1, A_EN,          32'h00000000, 32'h00000000, 1'b1};

    iRst_n = 1'b0; iAddr = 32'h0; iWrData = 32'h0; iMemWrite = 1'b0; iMemRead = 1'b0;
    iIrq = 4'h0; iKernel = 1'b0;

    // Reset held with iIrq toggling
    for (int i = 0; i < 4; i++) begin
      @(negedge iClk);
      iIrq = iIrq ^ 4'hF;
    end
    rdExp("rst_th", A_TH, 32'h0);
    rdExp("rst_tl", A_TL, 32'h0);
    rdExp("rst_tcon", A_TCON, 32'h0);
    rdExp("rst_en", A_EN, 32'h0);
    rdExp("rst_pend", A_PEND, 32'h0);
    rdExp("rst_cause", A_CAUS, 32'h0);
    check("rst_int", {31'h0, oInterrupt}, 32'h0);
    @(negedge iClk);
    iIrq = 4'hF;
    iRst_n = 1'b1;
    for (int i = 0; i < 5; i++) idle();
    rdExp("rel_pend", A_PEND, 32'h1E);
    check("rel_int", {31'h0, oInterrupt}, 32'h0);
    iIrq = 4'h0;
    wr(A_PEND, 32'h1F);
    rdExp("rel_pend_clr", A_PEND, 32'h0);

    // Register table, kernel mode so nothing is taken
    iKernel = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].doWr) wr(tbl[i].addr, tbl[i].wdata);
      rdExp(tbl[i].name, tbl[i].addr, tbl[i].expRd);
      iAddr = tbl[i].addr;
      #1;
      check({tbl[i].name, "_hit"}, {31'h0, oHit}, {31'h0, tbl[i].expHit});
    end
    iAddr = A_TH;
    iMemRead = 1'b0;
    #1;
    check("rd_strobe_low", oRdData, 32'h0);
    iKernel = 1'b0;

    // Timer overflow, take and return
    wr(A_TH, 32'hFFFFFFF0);
    wr(A_TL, 32'hFFFFFFFD);
    wr(A_EN, 32'h1);
    wr(A_TCON, 32'h1);
    rdExp("tmr_tl0", A_TL, 32'hFFFFFFFD);
    idle();
    rdExp("tmr_tl1", A_TL, 32'hFFFFFFFE);
    idle();
    rdExp("tmr_tl2", A_TL, 32'hFFFFFFFF);
    rdExp("tmr_pend2", A_PEND, 32'h0);
    check("tmr_int2", {31'h0, oInterrupt}, 32'h0);
    idle();
    rdExp("tmr_reload", A_TL, 32'hFFFFFFF0);
    rdExp("tmr_pend3", A_PEND, 32'h1);
    check("tmr_int3", {31'h0, oInterrupt}, 32'h1);
    idle();
    iKernel = 1'b1;
    rdExp("take_cause0", A_CAUS, 32'h0);
    check("svc_int", {31'h0, oInterrupt}, 32'h0);
    wr(A_TCON, 32'h0);
    wr(A_PEND, 32'h1);
    rdExp("svc_pend_clr", A_PEND, 32'h0);
    rdExp("tmr_hold", A_TL, 32'hFFFFFFF2);
    iKernel = 1'b0;
    #1;
    check("ret_int_pre", {31'h0, oInterrupt}, 32'h0);
    idle();
    check("ret_int_post", {31'h0, oInterrupt}, 32'h0);

    // Priority and back-to-back re-arm
    wr(A_EN, 32'h1F);
    iIrq = 4'b1010;
    idle();
    idle();
    iIrq = 4'b0000;
    waitInt("prio_wait");
    idle();
    iKernel = 1'b1;
    rdExp("prio_cause2", A_CAUS, 32'h2);
    rdExp("prio_pend", A_PEND, 32'h14);
    wr(A_PEND, 32'h4);
    iKernel = 1'b0;
    idle();
    check("b2b_int", {31'h0, oInterrupt}, 32'h1);
    idle();
    iKernel = 1'b1;
    rdExp("prio_cause4", A_CAUS, 32'h4);
    wr(A_PEND, 32'h10);
    iKernel = 1'b0;
    idle();
    check("prio_done_int", {31'h0, oInterrupt}, 32'h0);

    // Collisions: W1C vs overflow, TL write vs overflow
    iKernel = 1'b1;
    wr(A_EN, 32'h0);
    wr(A_TH, 32'h00000100);
    wr(A_TL, 32'hFFFFFFFE);
    wr(A_TCON, 32'h1);
    idle();
    wr(A_PEND, 32'h1);
    rdExp("col_w1c_pend", A_PEND, 32'h1);
    rdExp("col_w1c_tl", A_TL, 32'h100);
    wr(A_PEND, 32'h1);
    rdExp("col_pend_clr", A_PEND, 32'h0);
    wr(A_TL, 32'hFFFFFFFE);
    idle();
    wr(A_TL, 32'h00001234);
    rdExp("col_tlwr_tl", A_TL, 32'h1234);
    rdExp("col_tlwr_pend", A_PEND, 32'h0);
    wr(A_TCON, 32'h0);
    iKernel = 1'b0;

    // Reset asserted mid-service with CAUSE=3
    wr(A_EN, 32'h1F);
    iIrq = 4'b0100;
    idle();
    idle();
    iIrq = 4'b0000;
    waitInt("mid_wait");
    idle();
    iKernel = 1'b1;
    rdExp("mid_cause3", A_CAUS, 32'h3);
    iRst_n = 1'b0;
    iKernel = 1'b0;
    #1;
    rdExp("mid_rst_cause", A_CAUS, 32'h0);
    rdExp("mid_rst_pend", A_PEND, 32'h0);
    check("mid_rst_int", {31'h0, oInterrupt}, 32'h0);
    @(negedge iClk);
    iRst_n = 1'b1;
    wr(A_EN, 32'h2);
    iIrq = 4'b0001;
    idle();
    check("lat_int_e1", {31'h0, oInterrupt}, 32'h0);
    idle();
    check("lat_int_e2", {31'h0, oInterrupt}, 32'h0);
    idle();
    check("lat_int_e3", {31'h0, oInterrupt}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
